// File: rtl/mp_add_sequencer.sv
// Multi-precision add/subtract sequencer: one WIDTH+1-bit prefix adder reused per word, LSW first.
// Optional build macro MP_ADD_OVERFLOW_EN adds a registered signed-overflow output.

module prefix_tree_adder #(
  parameter int W = 9  // must be >= 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int LEVELS = $clog2(W);

  logic [W-1:0] h;
  logic [W-1:0] g;
  logic [W-1:0] p;

  // Kogge-Stone in vector form: each level doubles the span of every group (g, p).
  always_comb begin
    // NOTE: every variable written here gets a value before any branch/loop, so no latch is inferred.
    h = a ^ b;
    p = h;
    g = (a & b) | {{(W-1){1'b0}}, h[0] & cin};
    for (int l = 0; l < LEVELS; l++) begin
      g = g | (p & (g << (1 << l)));
      p = p & (p << (1 << l));
    end
  end

  assign sum  = h ^ {g[W-2:0], cin};
  assign cout = g[W-1];

endmodule

module mp_add_sequencer #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
`ifdef MP_ADD_OVERFLOW_EN
  output logic                   overflow,
`endif
  output logic                   busy
);

  localparam int TOT = WIDTH * WORDS;
  localparam int IW  = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             sub_r;
  logic [TOT-1:0]   a_r;
  logic [TOT-1:0]   b_r;
  logic [TOT-1:0]   sum_r;
  logic             cout_r;

  logic [WIDTH-1:0] word_a;
  logic [WIDTH-1:0] word_b;
  logic             last_word;
  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   add_y;
  logic [WIDTH:0]   add_res;
  logic             add_cout;
  logic             unused_lsb;

  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx == IW'(k)) begin
        word_a = a_r[k*WIDTH +: WIDTH];
        word_b = b_r[k*WIDTH +: WIDTH];
      end
    end
    if (sub_r) word_b = ~word_b;
  end

  assign last_word = (idx == IW'(WORDS - 1));

  // The carry rides in on an extra LSB pair (carry,carry), which generates exactly the carry
  // into bit 1; the adder's own cin stays 0.
  assign add_x = {word_a, carry};
  assign add_y = {word_b, carry};

  prefix_tree_adder #(.W(WIDTH + 1)) u_word_adder (
    .a    (add_x),
    .b    (add_y),
    .cin  (1'b0),
    .sum  (add_res),
    .cout (add_cout)
  );

  assign unused_lsb = add_res[0];

`ifdef MP_ADD_OVERFLOW_EN
  logic ovf_r;
  logic msb_cin;
  // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
  assign msb_cin = add_res[WIDTH] ^ word_a[WIDTH-1] ^ word_b[WIDTH-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: operand and result registers are reset too, so a discarded op leaves nothing behind.
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      sub_r  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
`ifdef MP_ADD_OVERFLOW_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
            carry <= sub;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (idx == IW'(k)) sum_r[k*WIDTH +: WIDTH] <= add_res[WIDTH:1];
          end
          carry <= add_cout;
          if (last_word) begin
            cout_r <= add_cout;
`ifdef MP_ADD_OVERFLOW_EN
            ovf_r  <= msb_cin ^ add_cout;
`endif
            idx    <= '0;
            state  <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
`ifdef MP_ADD_OVERFLOW_EN
  assign overflow  = ovf_r;
`endif

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer (WIDTH=8, WORDS=4) with hand-computed expected results.
// The overflow checks are compiled in when MP_ADD_OVERFLOW_EN is defined.

module tb_mp_add_sequencer;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int TOT   = WIDTH * WORDS;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [TOT-1:0] a;
  logic [TOT-1:0] b;
  logic           sub;
  logic           out_valid;
  logic           out_ready;
  logic [TOT-1:0] sum;
  logic           cout;
  logic           busy;
`ifdef MP_ADD_OVERFLOW_EN
  logic           overflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mp_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef MP_ADD_OVERFLOW_EN
    .overflow  (overflow),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction with fixed-latency checks; operands are scrambled after acceptance.
  task automatic run_op(input string tag, input logic [TOT-1:0] av, input logic [TOT-1:0] bv,
                        input logic sv, input logic [TOT-1:0] es, input logic ec, input logic eo);
    @(negedge clk);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = TOT'($urandom); b = TOT'($urandom); sub = ~sv;
    check({tag, ".busy"}, 64'(busy), 64'd1);
    repeat (WORDS - 1) tick();
    check({tag, ".early_valid"}, 64'(out_valid), 64'd0);
    tick();
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".sum"}, 64'(sum), 64'(es));
    check({tag, ".cout"}, 64'(cout), 64'(ec));
`ifdef MP_ADD_OVERFLOW_EN
    check({tag, ".overflow"}, 64'(overflow), 64'(eo));
`else
    if (eo !== eo) $display("unreachable");
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".released"}, 64'(out_valid), 64'd0);
    check({tag, ".idle_sum_hold"}, 64'(sum), 64'(es));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    #1;
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.sum", 64'(sum), 64'd0);
    check("rst.cout", 64'(cout), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic adds and subtracts
    run_op("add_ff_1",   32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
    run_op("add_wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("sub_borrow", 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("sub_equal",  32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 1'b0);
    run_op("sub_minpos", 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    run_op("add_mixed",  32'h89ABCDEF, 32'h76543211, 1'b0, 32'h00000000, 1'b1, 1'b0);

    // Backpressure in DONE with a new request already pending
    @(negedge clk);
    a = 32'h00000010; b = 32'h00000020; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (WORDS) tick();
    check("bp.out_valid", 64'(out_valid), 64'd1);
    check("bp.sum", 64'(sum), 64'h30);
    a = 32'h00000005; b = 32'h00000003; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.hold_valid", 64'(out_valid), 64'd1);
      check("bp.hold_sum", 64'(sum), 64'h30);
      check("bp.hold_cout", 64'(cout), 64'd0);
      check("bp.hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp.idle_in_ready", 64'(in_ready), 64'd1);
    check("bp.idle_busy", 64'(busy), 64'd0);
    check("bp.idle_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    check("bp.accepted_busy", 64'(busy), 64'd1);
    check("bp.accepted_in_ready", 64'(in_ready), 64'd0);
    check("bp.sum_until_run", 64'(sum), 64'h30);
    repeat (WORDS - 1) tick();
    check("bp2.early_valid", 64'(out_valid), 64'd0);
    tick();
    check("bp2.out_valid", 64'(out_valid), 64'd1);
    check("bp2.sum", 64'(sum), 64'h8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset while RUN is at word index 2
    @(negedge clk);
    a = 32'h11111111; b = 32'h22222222; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("arst.partial_sum", 64'(sum), 64'h00003333);
    #2 rst = 1'b1;
    #1;
    check("arst.out_valid", 64'(out_valid), 64'd0);
    check("arst.sum", 64'(sum), 64'd0);
    check("arst.in_ready", 64'(in_ready), 64'd1);
    check("arst.busy", 64'(busy), 64'd0);
    #1 rst = 1'b0;
    run_op("after_rst", 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0);

    // Signed overflow cases (overflow compared only when the port exists)
    run_op("ovf_pos",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("ovf_none", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
